alu_exec_stage: RTL and testbench

//  Execute stage directly downstream of the datapath shifter. Takes operand A and the shifter's

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 45 ++++
 rtl/alu_exec_stage.sv | 86 ++++++++
 tb/tb_alu_exec_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, status bit positions, buffer states.
package alu_pkg;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_V = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Signed overflow of x + y given the sign bits of x, y and the sum.
    function automatic logic add_ovf(input logic sx, input logic sy, input logic sr);
        return (sx == sy) && (sr != sx);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: ADD, SUB, AND, NOT B with Z/N/V flags on the raw result.
// Overflow flag only exists when ALU_OVERFLOW_EN is defined; otherwise v is tied low.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       aluop,
    output logic [WIDTH-1:0] r,
    output logic             z,
    output logic             n,
    output logic             v
);

    always_comb begin
        r = '0;
        case (aluop)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_NOTB: r = ~b;
            default:  r = 'x;
        endcase
    end

    assign z = (r == '0);
    assign n = r[WIDTH-1];

`ifdef ALU_OVERFLOW_EN
    // A - B overflows exactly when A + ~B would, looking only at sign bits.
    always_comb begin
        v = 1'b0;
        case (aluop)
            ALU_ADD: v = add_ovf(a[WIDTH-1], b[WIDTH-1], r[WIDTH-1]);
            ALU_SUB: v = add_ovf(a[WIDTH-1], ~b[WIDTH-1], r[WIDTH-1]);
            default: v = 1'b0;
        endcase
    end
`else
    assign v = 1'b0;
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage with a one-entry registered output buffer and {V,N,Z} status register.
// ALU_OVERFLOW_EN enables the V flag; without it status[2] stays 0.
//
// state    | meaning
// ST_EMPTY | no result held, always ready for input
// ST_FULL  | c_out holds an unconsumed result; input accepted only alongside a take
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic [1:0]       aluop,
    input  logic             loads,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c_out,
    output logic [2:0]       status
);

    state_t           state;
    logic [WIDTH-1:0] r;
    logic             z;
    logic             n;
    logic             v;
    logic             accept;
    logic             take;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a     (ain),
        .b     (bin),
        .aluop (aluop),
        .r     (r),
        .z     (z),
        .n     (n),
        .v     (v)
    );

    // Ready passes straight through from the consumer when full, so a stream has no bubbles.
    assign in_ready = (state == ST_EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;
    assign take     = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            c_out     <= '0;
            status    <= 3'b000;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        c_out     <= r;
                        state     <= ST_FULL;
                        out_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        c_out <= r;
                    end else if (take) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                end
            endcase

            if (accept && loads) begin
                status[ST_V] <= v;
                status[ST_N] <= n;
                status[ST_Z] <= z;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage (default build or with ALU_OVERFLOW_EN).
module tb_alu_exec_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [1:0]  aluop;
    logic        loads;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] c_out;
    logic [2:0]  status;

    int n_cmp = 0;
    int n_err = 0;

`ifdef ALU_OVERFLOW_EN
    localparam logic V_EN = 1'b1;
`else
    localparam logic V_EN = 1'b0;
`endif

    alu_exec_stage #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ain       (ain),
        .bin       (bin),
        .aluop     (aluop),
        .loads     (loads),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .status    (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present one op, let it be clocked in, deassert valid just after the edge.
    task automatic drive(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic ld);
        in_valid = 1'b1;
        aluop    = op;
        ain      = a;
        bin      = b;
        loads    = ld;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] ref_res(input logic [1:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        case (op)
            2'b00:   return 16'((32'(a) + 32'(b)) % 65536);
            2'b01:   return 16'((32'(a) + 65536 - 32'(b)) % 65536);
            2'b10:   return a & b;
            default: return ~b;
        endcase
    endfunction

    function automatic logic [2:0] ref_st(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        int          sa, sb, s;
        logic [15:0] res;
        logic        ov;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        res = ref_res(op, a, b);
        ov  = 1'b0;
        if (op == 2'b00) begin
            s  = sa + sb;
            ov = (s > 32767) || (s < -32768);
        end else if (op == 2'b01) begin
            s  = sa - sb;
            ov = (s > 32767) || (s < -32768);
        end
        return {ov & V_EN, res[15], res == 16'h0000};
    endfunction

    logic [1:0]  s_op [8];
    logic [15:0] s_a  [8];
    logic [15:0] s_b  [8];

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        ain       = '0;
        bin       = '0;
        aluop     = 2'b00;
        loads     = 1'b0;
        out_ready = 1'b1;

        // Reset values, then reach FULL with nonzero status and reset asynchronously mid-cycle.
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_c_out", 32'(c_out), 32'h0);
        chk("rst_status", 32'(status), 32'h0);
        #10;
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        out_ready = 1'b0;
        drive(2'b11, 16'h1234, 16'h0000, 1'b1);
        chk("pre_rst_c_out", 32'(c_out), 32'hFFFF);
        chk("pre_rst_status", 32'(status), 32'h2);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'h0);
        chk("async_c_out", 32'(c_out), 32'h0);
        chk("async_status", 32'(status), 32'h0);
        #2;
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // ADD 3 + 4
        drive(2'b00, 16'h0003, 16'h0004, 1'b1);
        chk("add_out_valid", 32'(out_valid), 32'h1);
        chk("add_c_out", 32'(c_out), 32'h0007);
        chk("add_status", 32'(status), 32'h0);

        // SUB equal -> zero, then ADD overflowing into the sign bit
        drive(2'b01, 16'h1234, 16'h1234, 1'b1);
        chk("sub_c_out", 32'(c_out), 32'h0000);
        chk("sub_status", 32'(status), 32'h1);
        drive(2'b00, 16'h7FFF, 16'h0001, 1'b1);
        chk("ovf_c_out", 32'(c_out), 32'h8000);
        chk("ovf_status", 32'(status), V_EN ? 32'h6 : 32'h2);

        // Backpressure: pending op with loads=1 must be ignored while stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        aluop     = 2'b01;
        ain       = 16'h0001;
        bin       = 16'h0002;
        loads     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            @(posedge clk);
            #1;
            chk("bp_c_out", 32'(c_out), 32'h8000);
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_status", 32'(status), V_EN ? 32'h6 : 32'h2);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept_c_out", 32'(c_out), 32'hFFFF);
        chk("bp_accept_valid", 32'(out_valid), 32'h1);
        chk("bp_accept_status", 32'(status), 32'h2);

        // AND without status load, then NOT B
        drive(2'b10, 16'hFF00, 16'h00FF, 1'b0);
        chk("and_c_out", 32'(c_out), 32'h0000);
        chk("and_status_hold", 32'(status), 32'h2);
        drive(2'b11, 16'h1234, 16'h00FF, 1'b0);
        chk("not_c_out", 32'(c_out), 32'hFF00);

        // Back-to-back stream against the reference model
        s_op = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01};
        s_a  = '{16'h1111, 16'h0005, 16'hF0F0, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h8000};
        s_b  = '{16'h2222, 16'h0007, 16'h3C3C, 16'hA5A5, 16'h8000, 16'hFFFF, 16'h0001, 16'h0001};
        for (int i = 0; i < 8; i++) begin
            drive(s_op[i], s_a[i], s_b[i], 1'b1);
            chk($sformatf("stream_c_out_%0d", i), 32'(c_out), 32'(ref_res(s_op[i], s_a[i], s_b[i])));
            chk($sformatf("stream_status_%0d", i), 32'(status), 32'(ref_st(s_op[i], s_a[i], s_b[i])));
            chk($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'h1);
        end
        @(posedge clk);
        #1;
        chk("drain_out_valid", 32'(out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
